stream_word_packer: RTL and testbench

//  Parametrised byte-stream-to-wide-word packer; next generation of the c8to512 stage between the pcap byte

---
 rtl/stream_word_packer.sv | 193 +++++++++++++++++++
 tb/tb_stream_word_packer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_word_packer.sv
// stream_word_packer
//   Packs a framed byte stream (IN_BYTES bytes per beat, SOP/EOP framing, ready/valid) into
//   DATA_WIDTH-bit words, each with a control word carrying SOP/EOP/ERR flags, the valid byte
//   count and the packet sequence number.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   in_data                beat bytes, first byte in the MSBs
//   in_valid, in_rdy       input handshake (in_rdy is combinational)
//   in_sop, in_eop         packet framing of the beat
//   in_nbytes              valid bytes on an EOP beat (0 or >IN_BYTES means IN_BYTES, flags ERR)
//   out_wr, out_rdy        output handshake; output register holds while out_wr & ~out_rdy
//   out_data               packed word, byte 0 at the MSBs, unused bytes zero
//   out_ctl                [0]SOP [1]EOP [2]ERR [15:8]bytes [31:16]seq, upper bits zero
//   pkt_count              completed packets, wraps
//   drop_cnt               beats dropped outside a packet, saturating
module stream_word_packer #(
  parameter int unsigned IN_BYTES   = 1,
  parameter int unsigned DATA_WIDTH = 480,
  parameter int unsigned CTRL_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*IN_BYTES-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [7:0]              in_nbytes,
  output logic                    in_rdy,
  output logic                    out_wr,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctl,
  output logic [15:0]             pkt_count,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned WordBytes  = DATA_WIDTH / 8;
  localparam int unsigned InBits     = 8 * IN_BYTES;
  localparam logic [8:0]  WordBytesW = 9'(WordBytes);
  localparam logic [7:0]  InBytesW   = 8'(IN_BYTES);

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic [15:0]             seq_q, seq_d;
  logic [7:0]              drop_q, drop_d;
  logic                    out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [31:0]             out_ctl_q, out_ctl_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [31:0]             pend_ctl_q, pend_ctl_d;

  logic                    nb_bad, beat_err;
  logic [7:0]              nb_eff, base_cnt;
  logic [InBits-1:0]       masked;
  logic [DATA_WIDTH-1:0]   top, base_acc, merged;
  logic [8:0]              sum_cnt;
  logic [15:0]             cur_seq;
  logic                    accept, out_free, start, abort, drop, close, base_first;
  logic [31:0]             abort_ctl, close_ctl;

  assign out_free = !out_wr_q || out_rdy;
  // A sop+closing beat arriving mid-packet yields two words in one cycle; the second waits in
  // the pending register and input is held off until it has moved to the output register.
  assign in_rdy   = out_free && !pend_valid_q;
  assign accept   = in_valid && in_rdy;

  // Beat datapath: effective byte count, masking and placement at the next free slot.
  always_comb begin
    nb_bad   = (in_nbytes == 8'd0) || (in_nbytes > InBytesW);
    nb_eff   = (in_eop && !nb_bad) ? in_nbytes : InBytesW;
    beat_err = in_eop && nb_bad;
    masked   = in_data;
    for (int i = 0; i < int'(IN_BYTES); i++) begin
      if (i >= int'(nb_eff)) masked[(int'(IN_BYTES) - 1 - i) * 8 +: 8] = 8'h00;
    end
    start      = accept && in_sop;
    abort      = start && (state_q == StInPkt);
    drop       = accept && !in_sop && (state_q == StIdle);
    base_cnt   = start ? 8'd0 : cnt_q;
    base_acc   = start ? '0 : acc_q;
    base_first = start ? 1'b1 : first_q;
    cur_seq    = abort ? seq_q + 16'd1 : seq_q;
    top        = '0;
    top[DATA_WIDTH-1 -: InBits] = masked;
    merged     = base_acc | (top >> {base_cnt, 3'b000});
    sum_cnt    = {1'b0, base_cnt} + {1'b0, nb_eff};
    close      = accept && !drop && (in_eop || (sum_cnt == WordBytesW));
    abort_ctl  = {seq_q, cnt_q, 5'b00000, 1'b1, 1'b1, first_q};
    close_ctl  = {cur_seq, sum_cnt[7:0], 5'b00000, beat_err, in_eop, base_first};
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    drop_d       = drop_q;
    out_wr_d     = out_wr_q && !out_rdy;
    out_data_d   = out_data_q;
    out_ctl_d    = out_ctl_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_ctl_d   = pend_ctl_q;
    // seq doubles as the completed-packet count: both step on every EOP word load
    seq_d        = seq_q + 16'(abort) + 16'(close && in_eop);

    if (pend_valid_q && out_free) begin
      out_wr_d     = 1'b1;
      out_data_d   = pend_data_q;
      out_ctl_d    = pend_ctl_q;
      pend_valid_d = 1'b0;
    end

    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (accept && !drop) begin
      if (close) begin
        acc_d   = '0;
        cnt_d   = 8'd0;
        first_d = in_eop;
        state_d = in_eop ? StIdle : StInPkt;
      end else begin
        acc_d   = merged;
        cnt_d   = sum_cnt[7:0];
        first_d = base_first;
        state_d = StInPkt;
      end
    end

    // An accepted beat guarantees the output register is free on this edge.
    if (abort) begin
      out_wr_d   = 1'b1;
      out_data_d = acc_q;
      out_ctl_d  = abort_ctl;
      if (close) begin
        pend_valid_d = 1'b1;
        pend_data_d  = merged;
        pend_ctl_d   = close_ctl;
      end
    end else if (close) begin
      out_wr_d   = 1'b1;
      out_data_d = merged;
      out_ctl_d  = close_ctl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= 8'd0;
      first_q      <= 1'b0;
      seq_q        <= 16'd0;
      drop_q       <= 8'd0;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      out_ctl_q    <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_ctl_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      seq_q        <= seq_d;
      drop_q       <= drop_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      out_ctl_q    <= out_ctl_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_ctl_q   <= pend_ctl_d;
    end
  end

  always_comb begin
    out_ctl       = '0;
    out_ctl[31:0] = out_ctl_q;
  end

  assign out_wr    = out_wr_q;
  assign out_data  = out_data_q;
  assign pkt_count = seq_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_word_packer.sv
module tb_stream_word_packer;
  localparam int DW = 480;
  localparam int WB = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // IN_BYTES=1 instance
  logic [7:0]    in_data = '0;
  logic          in_valid = 0, in_sop = 0, in_eop = 0;
  logic [7:0]    in_nbytes = 8'd1;
  logic          in_rdy, out_wr;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] out_data;
  logic [31:0]   out_ctl;
  logic [15:0]   pkt_count;
  logic [7:0]    drop_cnt;

  // IN_BYTES=4 instance
  logic [31:0]   in_data4 = '0;
  logic          in_valid4 = 0, in_sop4 = 0, in_eop4 = 0;
  logic [7:0]    in_nbytes4 = 8'd4;
  logic          in_rdy4, out_wr4;
  logic          out_rdy4 = 1'b1;
  logic [DW-1:0] out_data4;
  logic [39:0]   out_ctl4;
  logic [15:0]   pkt_count4;
  logic [7:0]    drop_cnt4;

  stream_word_packer #(.IN_BYTES(1), .DATA_WIDTH(DW), .CTRL_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_nbytes(in_nbytes), .in_rdy(in_rdy), .out_wr(out_wr),
    .out_rdy(out_rdy), .out_data(out_data), .out_ctl(out_ctl), .pkt_count(pkt_count),
    .drop_cnt(drop_cnt)
  );

  stream_word_packer #(.IN_BYTES(4), .DATA_WIDTH(DW), .CTRL_WIDTH(40)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_sop(in_sop4),
    .in_eop(in_eop4), .in_nbytes(in_nbytes4), .in_rdy(in_rdy4), .out_wr(out_wr4),
    .out_rdy(out_rdy4), .out_data(out_data4), .out_ctl(out_ctl4), .pkt_count(pkt_count4),
    .drop_cnt(drop_cnt4)
  );

  exp_t        sb[$];
  int          vecs = 0;
  int          errs = 0;
  logic [15:0] exp_seq = 16'd0;
  int          exp_pkts = 0;

  // Scoreboard: every transferred word must match the next expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && out_wr === 1'b1 && out_rdy === 1'b1) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_word ctl=%h (no word expected)", out_ctl);
      end else begin
        e = sb.pop_front();
        if (out_ctl !== e.ctl || out_data !== e.data) begin
          errs++;
          $display("FAIL word ctl=%h req %h data=%h req %h", out_ctl, e.ctl, out_data, e.data);
        end
      end
    end
  end

  // Expected words of one packet; bytes are (base+i) mod 256.
  function automatic void push_pkt(input int len, input int base, input bit abort,
                                   input bit bad_nb);
    exp_t e;
    int   pos = 0;
    int   n;
    bit   first = 1'b1;
    bit   last;
    if (abort) begin
      while (len - pos >= WB) begin
        e.data = '0;
        for (int k = 0; k < WB; k++) e.data[DW-1-8*k -: 8] = 8'(base + pos + k);
        e.ctl = {exp_seq, 8'(WB), 5'b0, 1'b0, 1'b0, first};
        sb.push_back(e);
        pos += WB;
        first = 1'b0;
      end
      n = len - pos;
      e.data = '0;
      for (int k = 0; k < n; k++) e.data[DW-1-8*k -: 8] = 8'(base + pos + k);
      e.ctl = {exp_seq, 8'(n), 5'b0, 1'b1, 1'b1, first};
      sb.push_back(e);
    end else begin
      while (pos < len) begin
        n = (len - pos > WB) ? WB : len - pos;
        last = (pos + n == len);
        e.data = '0;
        for (int k = 0; k < n; k++) e.data[DW-1-8*k -: 8] = 8'(base + pos + k);
        e.ctl = {exp_seq, 8'(n), 5'b0, last && bad_nb, last, first};
        sb.push_back(e);
        pos += n;
        first = 1'b0;
      end
    end
    exp_seq++;
    exp_pkts++;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eop,
                            input logic [7:0] nb);
    int waited = 0;
    in_data = d; in_sop = sop; in_eop = eop; in_nbytes = nb; in_valid = 1'b1;
    @(negedge clk);
    while (in_rdy !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      vecs++; errs++;
      $display("FAIL beat_accept_timeout in_rdy=%b required 1", in_rdy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drive4(input logic [31:0] d, input logic sop, input logic eop,
                        input logic [7:0] nb);
    int waited = 0;
    in_data4 = d; in_sop4 = sop; in_eop4 = eop; in_nbytes4 = nb; in_valid4 = 1'b1;
    @(negedge clk);
    while (in_rdy4 !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      vecs++; errs++;
      $display("FAIL beat4_accept_timeout in_rdy=%b required 1", in_rdy4);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_sop4 = 1'b0; in_eop4 = 1'b0;
  endtask

  task automatic drive_pkt(input int len, input int base, input bit abort, input bit bad_nb);
    push_pkt(len, base, abort, bad_nb);
    for (int i = 0; i < len; i++)
      drive_beat(8'(base + i), i == 0, !abort && (i == len - 1),
                 (bad_nb && i == len - 1) ? 8'd0 : 8'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_valid4 = 1'b0; out_rdy = 1'b1; out_rdy4 = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    exp_seq = 16'd0;
    exp_pkts = 0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && out_wr === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++; if (out_wr !== 1'b0) begin errs++; $display("FAIL rst_out_wr got %b req 0", out_wr); end
    vecs++; if (out_data !== '0) begin errs++; $display("FAIL rst_out_data got %h req 0", out_data); end
    vecs++; if (out_ctl !== 32'd0) begin errs++; $display("FAIL rst_out_ctl got %h req 0", out_ctl); end
    vecs++; if (pkt_count !== 16'd0) begin errs++; $display("FAIL rst_pkt_count got %h req 0", pkt_count); end
    vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL rst_drop_cnt got %h req 0", drop_cnt); end
    vecs++; if (in_rdy !== 1'b1) begin errs++; $display("FAIL rst_in_rdy got %b req 1", in_rdy); end
    @(posedge clk); #1 rst = 1'b1;
    // Word held on the output, then reset removes it.
    out_rdy = 1'b0;
    drive_beat(8'h55, 1'b1, 1'b1, 8'd1);
    vecs++; if (out_wr !== 1'b1) begin errs++; $display("FAIL held_word_wr got %b req 1", out_wr); end
    @(negedge clk); rst = 1'b0; #1;
    vecs++; if (out_wr !== 1'b0) begin errs++; $display("FAIL async_rst_wr got %b req 0", out_wr); end
    vecs++; if (out_ctl !== 32'd0) begin errs++; $display("FAIL async_rst_ctl got %h req 0", out_ctl); end
    vecs++; if (pkt_count !== 16'd0) begin errs++; $display("FAIL async_rst_cnt got %h req 0", pkt_count); end
    @(posedge clk); #1 rst = 1'b1; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if (out_wr !== 1'b0) begin errs++; $display("FAIL post_rst_wr got %b req 0", out_wr); end
  endtask

  task automatic test_two_word();
    bit ok;
    do_reset();
    drive_pkt(64, 0, 1'b0, 1'b0);
    vecs++; if (out_wr !== 1'b1) begin errs++; $display("FAIL tw_latency got %b req 1", out_wr); end
    vecs++; if (out_ctl !== 32'h0000_0402) begin errs++; $display("FAIL tw_ctl1 got %h req 00000402", out_ctl); end
    vecs++; if (out_data[479:448] !== 32'h3C3D3E3F) begin errs++; $display("FAIL tw_data1 got %h req 3c3d3e3f", out_data[479:448]); end
    vecs++; if (out_data[447:0] !== '0) begin errs++; $display("FAIL tw_data1_pad got %h req 0", out_data[447:0]); end
    vecs++; if (pkt_count !== 16'd1) begin errs++; $display("FAIL tw_pkt_count got %0d req 1", pkt_count); end
    wait_drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL tw_drain left=%0d req 0", sb.size()); end
  endtask

  task automatic test_seq();
    bit ok;
    do_reset();
    drive_pkt(60, 8'h00, 1'b0, 1'b0);
    vecs++; if (out_ctl !== 32'h0000_3C03) begin errs++; $display("FAIL seq_ctl0 got %h req 00003c03", out_ctl); end
    drive_pkt(60, 8'h60, 1'b0, 1'b0);
    vecs++; if (out_ctl !== 32'h0001_3C03) begin errs++; $display("FAIL seq_ctl1 got %h req 00013c03", out_ctl); end
    wait_drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL seq_drain left=%0d req 0", sb.size()); end
    vecs++; if (pkt_count !== 16'd2) begin errs++; $display("FAIL seq_pkt_count got %0d req 2", pkt_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit have = 1'b0;
    logic [DW-1:0] held = '0;
    do_reset();
    fork
      drive_pkt(64, 8'h40, 1'b0, 1'b0);
      begin
        repeat (55) @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (out_wr === 1'b1) begin
            vecs++;
            if (in_rdy !== 1'b0) begin errs++; $display("FAIL bp_in_rdy got %b req 0", in_rdy); end
            if (have) begin
              vecs++;
              if (out_data !== held) begin errs++; $display("FAIL bp_stable got %h req %h", out_data, held); end
            end
            held = out_data;
            have = 1'b1;
          end
        end
        vecs++; if (!have) begin errs++; $display("FAIL bp_stall_word got none req held word"); end
        @(posedge clk); #1 out_rdy = 1'b1;
      end
    join
    wait_drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL bp_drain left=%0d req 0", sb.size()); end
    vecs++; if (pkt_count !== 16'd1) begin errs++; $display("FAIL bp_pkt_count got %0d req 1", pkt_count); end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    drive_pkt(10, 8'h30, 1'b1, 1'b0);
    push_pkt(5, 8'h80, 1'b0, 1'b1);
    drive_beat(8'h80, 1'b1, 1'b0, 8'd1);
    vecs++; if (out_ctl !== 32'h0000_0A07) begin errs++; $display("FAIL abort_ctl got %h req 00000a07", out_ctl); end
    for (int i = 1; i < 5; i++) drive_beat(8'(8'h80 + i), 1'b0, i == 4, 8'd0);
    drive_pkt(60, 8'h00, 1'b1, 1'b0);   // abort right after a full word: empty EOP|ERR word
    drive_pkt(4, 8'hC0, 1'b1, 1'b0);
    drive_pkt(1, 8'hEE, 1'b0, 1'b0);    // single-beat packet aborting the previous one
    wait_drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL abort_drain left=%0d req 0", sb.size()); end
    vecs++; if (pkt_count !== 16'd5) begin errs++; $display("FAIL abort_pkt_count got %0d req 5", pkt_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit done = 1'b0;
    do_reset();
    fork
      begin
        drive_pkt(130, 8'h10, 1'b0, 1'b0);
        drive_pkt(7, 8'h99, 1'b0, 1'b0);
        drive_pkt(61, 8'h20, 1'b0, 1'b0);
        drive_pkt(120, 8'h05, 1'b0, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 out_rdy = 1'($urandom_range(0, 1));
        end
        out_rdy = 1'b1;
      end
    join
    wait_drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL b2b_drain left=%0d req 0", sb.size()); end
    vecs++; if (pkt_count !== 16'(exp_pkts)) begin errs++; $display("FAIL b2b_pkt_count got %0d req %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 5; i++) drive_beat(8'(i), 1'b0, i == 2, 8'd1);
    repeat (2) @(negedge clk);
    vecs++; if (out_wr !== 1'b0) begin errs++; $display("FAIL drop_no_wr got %b req 0", out_wr); end
    vecs++; if (drop_cnt !== 8'd5) begin errs++; $display("FAIL drop_cnt5 got %0d req 5", drop_cnt); end
    @(posedge clk); #1;
    for (int i = 0; i < 295; i++) drive_beat(8'hA5, 1'b0, 1'b0, 8'd1);
    vecs++; if (drop_cnt !== 8'd255) begin errs++; $display("FAIL drop_sat got %0d req 255", drop_cnt); end
    vecs++; if (pkt_count !== 16'd0) begin errs++; $display("FAIL drop_pkt_count got %0d req 0", pkt_count); end
  endtask

  task automatic test_wide();
    bit seen = 1'b0;
    do_reset();
    drive4(32'hA0A1A2A3, 1'b1, 1'b0, 8'd4);
    drive4(32'hA4A5A6A7, 1'b0, 1'b0, 8'd4);
    drive4(32'hA8A9AAFF, 1'b0, 1'b1, 8'd3);
    vecs++; if (out_wr4 !== 1'b1) begin errs++; $display("FAIL wide_wr got %b req 1", out_wr4); end
    vecs++; if (out_ctl4 !== 40'h00_0000_0B03) begin errs++; $display("FAIL wide_ctl got %h req 0000000b03", out_ctl4); end
    vecs++; if (out_data4[479:392] !== 88'hA0A1A2A3_A4A5A6A7_A8A9AA) begin errs++; $display("FAIL wide_data got %h req a0a1a2a3a4a5a6a7a8a9aa", out_data4[479:392]); end
    vecs++; if (out_data4[391:0] !== '0) begin errs++; $display("FAIL wide_pad got %h req 0", out_data4[391:0]); end
    vecs++; if (pkt_count4 !== 16'd1) begin errs++; $display("FAIL wide_pkt_count got %0d req 1", pkt_count4); end
    @(posedge clk); #1;
    drive4(32'h01020304, 1'b1, 1'b0, 8'd4);
    drive4(32'h05060708, 1'b0, 1'b0, 8'd4);
    @(negedge clk); rst = 1'b0; #1;
    vecs++; if (pkt_count4 !== 16'd0) begin errs++; $display("FAIL wide_rst_cnt got %0d req 0", pkt_count4); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_wr4 !== 1'b0) seen = 1'b1;
    end
    vecs++; if (seen) begin errs++; $display("FAIL wide_no_partial got out_wr=1 req 0"); end
    @(posedge clk); #1;
    drive4(32'h11223344, 1'b1, 1'b1, 8'd4);
    vecs++; if (out_ctl4 !== 40'h00_0000_0403) begin errs++; $display("FAIL wide_after_rst_ctl got %h req 0000000403", out_ctl4); end
    vecs++; if (out_data4[479:448] !== 32'h11223344) begin errs++; $display("FAIL wide_after_rst_data got %h req 11223344", out_data4[479:448]); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_seq();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_drop();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
